// File: rtl/partition_err_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : partition_err_monitor
//  Description : Exhaustive error monitor for an approximate logic partition.
//                On start it walks every input vector 0 .. 2^IN_W-1 on pi,
//                one vector per cycle. After LAT cycles it samples the
//                approximate (po_apx) and exact (po_ref) responses and
//                accumulates error statistics. done pulses for one cycle when
//                the last vector has been accumulated.
//  Parameters  : IN_W  - partition input width (2^IN_W vectors per sweep)
//                OUT_W - partition output width
//                LAT   - 0..3, cycles from pi to matching po_apx/po_ref
//  Ports       : clk, rst (synchronous, active-high), start
//                pi               - stimulus vector driven to both partitions
//                po_apx, po_ref   - partition responses
//                busy             - sweep in progress (RUN or DRAIN)
//                done             - one-cycle pulse, final totals valid
//                err_cnt          - number of vectors with po_apx != po_ref
//                ham_sum          - summed Hamming distance
//                abs_sum          - summed |po_apx - po_ref| (unsigned)
//                max_err, max_vec - worst |diff| and first vector reaching it
//  Options     : define PARTITION_ERR_MAX_EN to build max_err/max_vec
//                tracking; otherwise both ports are tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module partition_err_monitor #(
    parameter int IN_W  = 7,
    parameter int OUT_W = 4,
    parameter int LAT   = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic [IN_W-1:0]               pi,
    input  logic [OUT_W-1:0]              po_apx,
    input  logic [OUT_W-1:0]              po_ref,
    output logic                          busy,
    output logic                          done,
    output logic [IN_W:0]                 err_cnt,
    output logic [IN_W+$clog2(OUT_W):0]   ham_sum,
    output logic [IN_W+OUT_W-1:0]         abs_sum,
    output logic [OUT_W-1:0]              max_err,
    output logic [IN_W-1:0]               max_vec
);

    localparam int              c_ERR_W = IN_W + 1;
    localparam int              c_HAM_W = IN_W + $clog2(OUT_W) + 1;
    localparam int              c_ABS_W = IN_W + OUT_W;
    localparam logic [IN_W-1:0] c_LAST  = '1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    logic [1:0]          r_state;
    logic [IN_W-1:0]     r_pi;
    logic                r_done;
    logic [c_ERR_W-1:0]  r_err;
    logic [c_HAM_W-1:0]  r_ham;
    logic [c_ABS_W-1:0]  r_abs;

    // ------------------------------------------------------------------------
    // Vector tag pipeline. Index 0 is the vector on pi this cycle (valid while
    // RUN); index k is the vector driven k cycles ago. The responses belong
    // to the tag at index LAT.
    // ------------------------------------------------------------------------
    logic [LAT:0]            w_vld;
    logic [LAT:0][IN_W-1:0]  w_vec;

    generate
        if (LAT > 0) begin : g_pipe
            logic [LAT-1:0]            r_vld;
            logic [LAT-1:0][IN_W-1:0]  r_vec;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_vld <= '0;
                    r_vec <= '0;
                end else begin
                    r_vld <= w_vld[LAT-1:0];
                    r_vec <= w_vec[LAT-1:0];
                end
            end

            assign w_vld = {r_vld, (r_state == c_RUN)};
            assign w_vec = {r_vec, r_pi};
        end else begin : g_nopipe
            assign w_vld = (r_state == c_RUN);
            assign w_vec = r_pi;
        end
    endgenerate

    logic             w_smp;
    logic [IN_W-1:0]  w_tag;
    logic             w_last;

    assign w_smp  = w_vld[LAT];
    assign w_tag  = w_vec[LAT];
    // Final vector reaches the sampling point: accumulate it and finish.
    assign w_last = w_smp && (w_tag == c_LAST);

    // ------------------------------------------------------------------------
    // Per-vector error metrics
    // ------------------------------------------------------------------------
    logic [OUT_W-1:0]    w_x;
    logic [OUT_W-1:0]    w_abs;
    logic                w_ne;
    logic [c_HAM_W-1:0]  w_pop;

    assign w_x   = po_apx ^ po_ref;
    assign w_ne  = |w_x;
    // Operands are unsigned; subtract the smaller from the larger.
    assign w_abs = (po_apx >= po_ref) ? (po_apx - po_ref) : (po_ref - po_apx);

    always_comb begin
        w_pop = '0;
        for (int b = 0; b < OUT_W; b++) begin
            w_pop = w_pop + {{(c_HAM_W-1){1'b0}}, w_x[b]};
        end
    end

    logic w_accept;
    assign w_accept = (r_state == c_IDLE) && start;

    // ------------------------------------------------------------------------
    // Sweep control
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_pi    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_last;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_state <= c_RUN;
                        r_pi    <= '0;
                    end
                end
                c_RUN: begin
                    // pi stops on the last vector; it is not wrapped.
                    if (r_pi == c_LAST) begin
                        r_state <= (LAT == 0) ? c_IDLE : c_DRAIN;
                    end else begin
                        r_pi <= r_pi + 1'b1;
                    end
                end
                c_DRAIN: begin
                    if (w_last) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Accumulators (widths cover a full sweep, so no overflow handling)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_err <= '0;
            r_ham <= '0;
            r_abs <= '0;
        end else if (w_smp) begin
            r_err <= r_err + {{IN_W{1'b0}}, w_ne};
            r_ham <= r_ham + w_pop;
            r_abs <= r_abs + {{IN_W{1'b0}}, w_abs};
        end
    end

`ifdef PARTITION_ERR_MAX_EN
    logic [OUT_W-1:0] r_max_err;
    logic [IN_W-1:0]  r_max_vec;

    // Strict compare keeps the first vector that reaches the worst error.
    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_max_err <= '0;
            r_max_vec <= '0;
        end else if (w_smp && (w_abs > r_max_err)) begin
            r_max_err <= w_abs;
            r_max_vec <= w_tag;
        end
    end

    assign max_err = r_max_err;
    assign max_vec = r_max_vec;
`else
    assign max_err = '0;
    assign max_vec = '0;
`endif

    assign pi      = r_pi;
    assign busy    = (r_state != c_IDLE);
    assign done    = r_done;
    assign err_cnt = r_err;
    assign ham_sum = r_ham;
    assign abs_sum = r_abs;

endmodule
`default_nettype wire

// File: tb/tb_partition_err_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_partition_err_monitor
//  Description : Self-checking bench for partition_err_monitor. Two instances
//                (LAT=0 and LAT=2) share clock, reset and start. Partition
//                responses come from per-sweep lookup tables; the LAT=2
//                instance sees them through a two-cycle delay. Expected totals
//                are computed directly from the tables.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_partition_err_monitor;

    localparam int IN_W  = 7;
    localparam int OUT_W = 4;
    localparam int NV    = 1 << IN_W;
    localparam int HAM_W = IN_W + $clog2(OUT_W) + 1;

    logic clk = 1'b0;
    logic rst;
    logic start;

    logic [NV*OUT_W-1:0] ref_flat;
    logic [NV*OUT_W-1:0] apx_flat;

    logic [IN_W-1:0]        pi0, pi2, pd1, pd2;
    logic [OUT_W-1:0]       apx0, ref0, apx2, ref2;
    logic                   busy0, busy2, done0, done2;
    logic [IN_W:0]          err0, err2;
    logic [HAM_W-1:0]       ham0, ham2;
    logic [IN_W+OUT_W-1:0]  abs0, abs2;
    logic [OUT_W-1:0]       mx0, mx2;
    logic [IN_W-1:0]        mv0, mv2;

    int n_cmp = 0;
    int n_bad = 0;

    int e_err, e_ham, e_abs, e_max, e_vec;

    always #5 clk = ~clk;

    // Responses of the partitions under test
    assign ref0 = ref_flat[pi0*OUT_W +: OUT_W];
    assign apx0 = apx_flat[pi0*OUT_W +: OUT_W];

    always @(posedge clk) begin
        pd1 <= pi2;
        pd2 <= pd1;
    end
    assign ref2 = ref_flat[pd2*OUT_W +: OUT_W];
    assign apx2 = apx_flat[pd2*OUT_W +: OUT_W];

    partition_err_monitor #(.IN_W(IN_W), .OUT_W(OUT_W), .LAT(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .pi(pi0),
        .po_apx(apx0), .po_ref(ref0), .busy(busy0), .done(done0),
        .err_cnt(err0), .ham_sum(ham0), .abs_sum(abs0),
        .max_err(mx0), .max_vec(mv0)
    );

    partition_err_monitor #(.IN_W(IN_W), .OUT_W(OUT_W), .LAT(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .pi(pi2),
        .po_apx(apx2), .po_ref(ref2), .busy(busy2), .done(done2),
        .err_cnt(err2), .ham_sum(ham2), .abs_sum(abs2),
        .max_err(mx2), .max_vec(mv2)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Reference totals straight from the response tables.
    task automatic model();
        int a, r, d;
        e_err = 0; e_ham = 0; e_abs = 0; e_max = 0; e_vec = 0;
        for (int v = 0; v < NV; v++) begin
            a = int'(apx_flat[v*OUT_W +: OUT_W]);
            r = int'(ref_flat[v*OUT_W +: OUT_W]);
            d = (a > r) ? a - r : r - a;
            if (a != r) e_err++;
            e_ham += $countones(a ^ r);
            e_abs += d;
            if (d > e_max) begin
                e_max = d;
                e_vec = v;
            end
        end
`ifndef PARTITION_ERR_MAX_EN
        e_max = 0;
        e_vec = 0;
`endif
    endtask

    task automatic fill(input int mode);
        for (int v = 0; v < NV; v++) begin
            case (mode)
                0: begin
                    ref_flat[v*OUT_W +: OUT_W] = 4'($urandom);
                    apx_flat[v*OUT_W +: OUT_W] = ref_flat[v*OUT_W +: OUT_W];
                end
                1: begin
                    ref_flat[v*OUT_W +: OUT_W] = 4'($urandom);
                    apx_flat[v*OUT_W +: OUT_W] = ref_flat[v*OUT_W +: OUT_W] ^ 4'b0001;
                end
                2: begin
                    ref_flat[v*OUT_W +: OUT_W] = 4'(v);
                    apx_flat[v*OUT_W +: OUT_W] = 4'd0;
                end
                default: begin
                    ref_flat[v*OUT_W +: OUT_W] = 4'($urandom);
                    apx_flat[v*OUT_W +: OUT_W] = 4'($urandom);
                end
            endcase
        end
    endtask

    task automatic check_results(input string nm);
        chk($sformatf("%s_err0", nm), 32'(err0), 32'(e_err));
        chk($sformatf("%s_ham0", nm), 32'(ham0), 32'(e_ham));
        chk($sformatf("%s_abs0", nm), 32'(abs0), 32'(e_abs));
        chk($sformatf("%s_maxerr0", nm), 32'(mx0), 32'(e_max));
        chk($sformatf("%s_maxvec0", nm), 32'(mv0), 32'(e_vec));
        chk($sformatf("%s_err2", nm), 32'(err2), 32'(e_err));
        chk($sformatf("%s_ham2", nm), 32'(ham2), 32'(e_ham));
        chk($sformatf("%s_abs2", nm), 32'(abs2), 32'(e_abs));
        chk($sformatf("%s_maxerr2", nm), 32'(mx2), 32'(e_max));
        chk($sformatf("%s_maxvec2", nm), 32'(mv2), 32'(e_vec));
    endtask

    task automatic check_zero(input string nm);
        chk($sformatf("%s_zero0", nm),
            32'({pi0, busy0, done0} | {err0} | {ham0} | {abs0} | {mx0} | {mv0}), 32'd0);
        chk($sformatf("%s_zero2", nm),
            32'({pi2, busy2, done2} | {err2} | {ham2} | {abs2} | {mx2} | {mv2}), 32'd0);
    endtask

    // One full sweep launched by a single-cycle start pulse.
    task automatic sweep(input string nm, input int mode);
        int t0, t2, nd0, nd2;
        t0 = -1; t2 = -1; nd0 = 0; nd2 = 0;
        fill(mode);
        model();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk($sformatf("%s_busy_after_start", nm), 32'(busy0 & busy2), 32'd1);
        for (int n = 1; n <= 140; n++) begin
            @(negedge clk);
            if (done0) begin nd0++; if (t0 < 0) t0 = n; end
            if (done2) begin nd2++; if (t2 < 0) t2 = n; end
        end
        chk($sformatf("%s_done_edge0", nm), 32'(t0), 32'(NV));
        chk($sformatf("%s_done_edge2", nm), 32'(t2), 32'(NV + 2));
        chk($sformatf("%s_done_count0", nm), 32'(nd0), 32'd1);
        chk($sformatf("%s_done_count2", nm), 32'(nd2), 32'd1);
        chk($sformatf("%s_idle", nm), 32'({busy0, busy2}), 32'd0);
        chk($sformatf("%s_pi_hold0", nm), 32'(pi0), 32'(NV - 1));
        chk($sformatf("%s_pi_hold2", nm), 32'(pi2), 32'(NV - 1));
        check_results(nm);
    endtask

    initial begin
        int nd;
        bit hit;
        rst = 1'b1;
        start = 1'b0;
        ref_flat = '0;
        apx_flat = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_zero("reset");

        sweep("equal", 0);
        sweep("lsb_flip", 1);
        sweep("ramp_vs_zero", 2);
        sweep("random_a", 3);
        sweep("random_b", 3);

        // Reset in the middle of a sweep.
        fill(3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        nd = 0;
        for (int n = 0; n < 200 && !hit; n++) begin
            if (pi0 == 7'd50) hit = 1'b1;
            else begin
                @(negedge clk);
                if (done0 || done2) nd++;
            end
        end
        chk("rst_reach_pi50", 32'(pi0), 32'd50);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero("mid_rst");
        for (int n = 0; n < 140; n++) begin
            @(negedge clk);
            if (done0 || done2) nd++;
        end
        chk("mid_rst_no_done", 32'(nd), 32'd0);
        check_zero("mid_rst_stay");
        sweep("after_rst", 3);

        // Start held high across the whole run.
        fill(3);
        model();
        begin
            int t0, t2, nd0, nd2;
            t0 = -1; t2 = -1; nd0 = 0; nd2 = 0;
            start = 1'b1;
            @(negedge clk);
            for (int n = 1; n <= 140; n++) begin
                @(negedge clk);
                if (done0) begin
                    nd0++;
                    if (t0 < 0) t0 = n;
                    chk("held_err0_at_done", 32'(err0), 32'(e_err));
                    chk("held_abs0_at_done", 32'(abs0), 32'(e_abs));
                end
                if (done2) begin
                    nd2++;
                    if (t2 < 0) t2 = n;
                    chk("held_ham2_at_done", 32'(ham2), 32'(e_ham));
                end
                if (n == NV + 1) begin
                    chk("held_restart_pi0", 32'(pi0), 32'd0);
                    chk("held_restart_busy0", 32'(busy0), 32'd1);
                end
                if (n == NV + 3) begin
                    chk("held_restart_pi2", 32'(pi2), 32'd0);
                    chk("held_restart_busy2", 32'(busy2), 32'd1);
                end
            end
            chk("held_done_edge0", 32'(t0), 32'(NV));
            chk("held_done_edge2", 32'(t2), 32'(NV + 2));
            chk("held_done_count0", 32'(nd0), 32'd1);
            chk("held_done_count2", 32'(nd2), 32'd1);
            start = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check_zero("held_cleanup");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
